// File: rtl/turfio_eye_align_if.sv
// turfio_eye_align_if: bundles the control/status and deserializer bus of the
// TURFIO eye-alignment controller.
//   master : the alignment controller (takes start/mask/data, drives IDELAY
//            load signals and per-channel results)
//   slave  : the surrounding logic (software regs, ISERDES/IDELAY wrapper)
// Channel c occupies [c*DWIDTH +: DWIDTH] of the data buses, [c*9 +: 9] of the
// tap buses and [c*SW +: SW] of bitslip_o.
interface turfio_eye_align_if #(
    parameter int NBITS  = 4,
    parameter int DWIDTH = 4
);
    localparam int SW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

    logic                      start_i;
    logic [NBITS-1:0]          chan_mask_i;
    logic [NBITS*DWIDTH-1:0]   data_i;
    logic [NBITS-1:0]          delay_load_o;
    logic [1:0]                delay_sel_o;
    logic [8:0]                delay_cntvaluein_o;
    logic                      busy_o;
    logic                      done_o;
    logic [NBITS-1:0]          err_o;
    logic [NBITS*9-1:0]        eye_center_o;
    logic [NBITS*9-1:0]        eye_width_o;
    logic [NBITS*SW-1:0]       bitslip_o;
    logic [NBITS*DWIDTH-1:0]   aligned_data_o;

    modport master (
        input  start_i, chan_mask_i, data_i,
        output delay_load_o, delay_sel_o, delay_cntvaluein_o, busy_o, done_o,
               err_o, eye_center_o, eye_width_o, bitslip_o, aligned_data_o
    );

    modport slave (
        output start_i, chan_mask_i, data_i,
        input  delay_load_o, delay_sel_o, delay_cntvaluein_o, busy_o, done_o,
               err_o, eye_center_o, eye_width_o, bitslip_o, aligned_data_o
    );
endinterface

// File: rtl/turfio_eye_align.sv
// turfio_eye_align: sweeps the IDELAY of each enabled receive channel, finds the
// widest run of tap points whose ISERDES output is a stable rotation of PATTERN,
// loads the channel to the centre of that run and reports bitslip/eye results.
// Ports:
//   if_clk_i : interface clock (only clock)
//   rst_n_i  : asynchronous active-low reset
//   bus      : turfio_eye_align_if.master (start/mask/data in, IDELAY load and
//              per-channel err/center/width/bitslip/aligned data out)
module turfio_eye_align #(
    parameter int                NBITS         = 4,
    parameter int                DWIDTH        = 4,
    parameter logic [DWIDTH-1:0] PATTERN       = 4'b1000,
    parameter int                DELAY_STEP    = 32,
    parameter int                DELAY_MAX     = 511,
    parameter int                SETTLE_CYCLES = 16,
    parameter int                SAMPLE_LOG2   = 8,
    parameter int                MIN_EYE       = 64
) (
    input logic                if_clk_i,
    input logic                rst_n_i,
    turfio_eye_align_if.master bus
);
    localparam int SW  = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam int CHW = $clog2(NBITS + 1);
    localparam int CIW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int CW  = (SAMPLE_LOG2 > $clog2(SETTLE_CYCLES + 1)) ? SAMPLE_LOG2
                                                                   : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [3:0] {
        StIdle, StSel, StLoad, StSettle, StSample, StEval, StCenter, StCsettle, StSlip, StDone
    } state_e;

    function automatic logic [DWIDTH-1:0] rotl(input logic [DWIDTH-1:0] v, input int r);
        logic [DWIDTH-1:0] o;
        o = '0;
        for (int i = 0; i < DWIDTH; i++) o[SW'((i + r) % DWIDTH)] = v[i];
        return o;
    endfunction

    function automatic logic [DWIDTH-1:0] rotr(input logic [DWIDTH-1:0] v,
                                               input logic [SW-1:0] s);
        logic [DWIDTH-1:0] o;
        o = '0;
        for (int i = 0; i < DWIDTH; i++) o[i] = v[SW'((i + int'(s)) % DWIDTH)];
        return o;
    endfunction

    // {found, lowest r with v == rotl(PATTERN, r)}
    function automatic logic [SW:0] find_rot(input logic [DWIDTH-1:0] v);
        logic          found;
        logic [SW-1:0] r;
        found = 1'b0;
        r     = '0;
        for (int k = DWIDTH - 1; k >= 0; k--) begin
            if (v == rotl(PATTERN, k)) begin
                found = 1'b1;
                r     = SW'(k);
            end
        end
        return {found, r};
    endfunction

    state_e                        state_q;
    logic [NBITS-1:0]              mask_q;
    logic [CHW-1:0]                ch_q;
    logic [8:0]                    tap_q;
    logic [CW-1:0]                 cnt_q;
    logic [DWIDTH-1:0]             ref_q;
    logic                          fail_q;
    logic                          run_open_q, best_valid_q;
    logic [8:0]                    run_start_q, run_end_q, best_start_q, best_end_q;
    logic [NBITS-1:0]              load_q, err_q;
    logic [8:0]                    cntval_q;
    logic                          busy_q, done_q;
    logic [NBITS-1:0][8:0]         center_q, width_q;
    logic [NBITS-1:0][SW-1:0]      bitslip_q;
    logic [NBITS-1:0][DWIDTH-1:0]  aligned_q;

    logic [NBITS-1:0][DWIDTH-1:0]  data_ch;
    logic [CIW-1:0]                chi;
    logic [DWIDTH-1:0]             cur;
    logic                          cur_found;
    logic [SW-1:0]                 cur_rot;
    logic                          sel_found;
    logic [CHW-1:0]                sel_ch;
    logic                          last_pt, pass, close_en, take_best, best_ok;
    logic [8:0]                    close_rs, close_re, best_width, center_val;

    assign data_ch = bus.data_i;

    always_comb begin
        chi                  = ch_q[CIW-1:0];
        cur                  = data_ch[chi];
        {cur_found, cur_rot} = find_rot(cur);

        // Next enabled channel at or above ch, found in one cycle.
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int c = 0; c < NBITS; c++) begin
            if (!sel_found && mask_q[c] && c >= int'(ch_q)) begin
                sel_found = 1'b1;
                sel_ch    = CHW'(c);
            end
        end

        // 10-bit compare so the step never wraps past the top tap.
        last_pt  = ({1'b0, tap_q} + 10'(DELAY_STEP)) > 10'(DELAY_MAX);
        pass     = !fail_q;
        // A run closes on a fail, or on a pass at the final point.
        close_en = pass ? last_pt : run_open_q;
        close_rs = (pass && !run_open_q) ? tap_q : run_start_q;
        close_re = pass ? tap_q : run_end_q;
        best_width = best_end_q - best_start_q;
        take_best  = close_en && (!best_valid_q || ((close_re - close_rs) > best_width));
        best_ok    = best_valid_q && (best_width >= 9'(MIN_EYE));
        center_val = best_start_q + (best_width >> 1);
    end

    always_ff @(posedge if_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= StIdle;
            mask_q       <= '0;
            ch_q         <= '0;
            tap_q        <= '0;
            cnt_q        <= '0;
            ref_q        <= '0;
            fail_q       <= 1'b0;
            run_open_q   <= 1'b0;
            best_valid_q <= 1'b0;
            run_start_q  <= '0;
            run_end_q    <= '0;
            best_start_q <= '0;
            best_end_q   <= '0;
            load_q       <= '0;
            err_q        <= '0;
            cntval_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            center_q     <= '0;
            width_q      <= '0;
            bitslip_q    <= '0;
            aligned_q    <= '0;
        end else begin
            load_q <= '0;
            done_q <= 1'b0;
            for (int c = 0; c < NBITS; c++) aligned_q[c] <= rotr(data_ch[c], bitslip_q[c]);

            unique case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        mask_q <= bus.chan_mask_i;
                        ch_q   <= '0;
                        busy_q <= 1'b1;
                        for (int c = 0; c < NBITS; c++) begin
                            if (bus.chan_mask_i[c]) begin
                                err_q[c]    <= 1'b0;
                                center_q[c] <= '0;
                                width_q[c]  <= '0;
                            end
                        end
                        state_q <= StSel;
                    end
                end
                StSel: begin
                    if (!sel_found) begin
                        state_q <= StDone;
                    end else begin
                        ch_q         <= sel_ch;
                        tap_q        <= '0;
                        run_open_q   <= 1'b0;
                        run_start_q  <= '0;
                        run_end_q    <= '0;
                        best_valid_q <= 1'b0;
                        best_start_q <= '0;
                        best_end_q   <= '0;
                        state_q      <= StLoad;
                    end
                end
                StLoad: begin
                    load_q   <= NBITS'(1) << chi;
                    cntval_q <= tap_q;
                    cnt_q    <= '0;
                    state_q  <= StSettle;
                end
                StSettle: begin
                    if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StSample;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StSample: begin
                    if (cnt_q == '0) begin
                        ref_q  <= cur;
                        fail_q <= !cur_found;
                    end else if (cur != ref_q) begin
                        fail_q <= 1'b1;
                    end
                    if (cnt_q == CW'((1 << SAMPLE_LOG2) - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StEval;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StEval: begin
                    if (pass) begin
                        if (!run_open_q) run_start_q <= tap_q;
                        run_end_q <= tap_q;
                    end
                    run_open_q <= pass && !last_pt;
                    if (take_best) begin
                        best_valid_q <= 1'b1;
                        best_start_q <= close_rs;
                        best_end_q   <= close_re;
                    end
                    if (last_pt) begin
                        state_q <= StCenter;
                    end else begin
                        tap_q   <= tap_q + 9'(DELAY_STEP);
                        state_q <= StLoad;
                    end
                end
                StCenter: begin
                    load_q        <= NBITS'(1) << chi;
                    cntval_q      <= best_ok ? center_val : 9'd0;
                    center_q[chi] <= best_ok ? center_val : 9'd0;
                    width_q[chi]  <= best_valid_q ? best_width : 9'd0;
                    if (!best_ok) err_q[chi] <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= StCsettle;
                end
                StCsettle: begin
                    if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StSlip;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StSlip: begin
                    bitslip_q[chi] <= cur_found ? cur_rot : '0;
                    if (!cur_found) err_q[chi] <= 1'b1;
                    ch_q    <= ch_q + 1'b1;
                    state_q <= StSel;
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.delay_load_o       = load_q;
    assign bus.delay_sel_o        = 2'b00;
    assign bus.delay_cntvaluein_o = cntval_q;
    assign bus.busy_o             = busy_q;
    assign bus.done_o             = done_q;
    assign bus.err_o              = err_q;
    assign bus.eye_center_o       = center_q;
    assign bus.eye_width_o        = width_q;
    assign bus.bitslip_o          = bitslip_q;
    assign bus.aligned_data_o     = aligned_q;
endmodule

// File: tb/tb_turfio_eye_align.sv
// tb_turfio_eye_align: directed bench for turfio_eye_align with NBITS=2. Channel 0
// is an IDELAY/ISERDES model whose output passes (rotl(1000,2) = 0010) only inside
// programmable tap windows; channel 1 always shows 0001 and is never scanned.
module tb_turfio_eye_align;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    int   lo1, hi1, lo2, hi2, gl_tap;
    int   tap_m   = 0;
    int   since   = 0;
    int   ld0_tot = 0;
    int   ld1_tot = 0;
    int   ld0_base, ld1_base;
    logic [3:0] d0;

    turfio_eye_align_if #(.NBITS(2), .DWIDTH(4)) bus ();

    turfio_eye_align #(.NBITS(2)) dut (
        .if_clk_i (clk),
        .rst_n_i  (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // IDELAY model: the loaded tap takes effect from the next cycle.
    always @(posedge clk) begin
        if (bus.delay_load_o[0]) begin
            tap_m <= int'(bus.delay_cntvaluein_o);
            since <= 0;
        end else begin
            since <= since + 1;
        end
        if (bus.delay_load_o[0]) ld0_tot <= ld0_tot + 1;
        if (bus.delay_load_o[1]) ld1_tot <= ld1_tot + 1;
    end

    always_comb begin
        d0 = ((tap_m >= lo1 && tap_m <= hi1) || (tap_m >= lo2 && tap_m <= hi2)) ? 4'b0010
                                                                                : 4'b0000;
        // single bad sample well inside the sample window
        if (tap_m == gl_tap && since == 100) d0 = 4'b0000;
        bus.data_i = {4'b0001, d0};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_eye(input int a1, input int b1, input int a2, input int b2,
                           input int g);
        lo1 = a1; hi1 = b1; lo2 = a2; hi2 = b2; gl_tap = g;
    endtask

    task automatic start_scan(input logic [1:0] mask);
        ld0_base = ld0_tot;
        ld1_base = ld1_tot;
        @(negedge clk);
        bus.chan_mask_i = mask;
        bus.start_i     = 1'b1;
        @(negedge clk);
        bus.start_i     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 12000 && !got; i++) begin
            @(negedge clk);
            if (bus.done_o) got = 1'b1;
        end
        check({tag, "_done"}, 32'(got), 32'd1);
    endtask

    task automatic check_ch0(input string tag, input int center, input int width,
                             input int err);
        check({tag, "_center"}, 32'(bus.eye_center_o[8:0]), 32'(center));
        check({tag, "_width"},  32'(bus.eye_width_o[8:0]),  32'(width));
        check({tag, "_err"},    32'(bus.err_o[0]),          32'(err));
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.start_i     = 1'b0;
        bus.chan_mask_i = 2'b00;
        set_eye(1000, -1, 1000, -1, -1);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_load", 32'(bus.delay_load_o), 32'd0);
        check("rst_sel",  32'(bus.delay_sel_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single eye 128..320
        set_eye(128, 320, 1000, -1, -1);
        start_scan(2'b01);
        check("single_busy", 32'(bus.busy_o), 32'd1);
        wait_done("single");
        check("single_busy_fall", 32'(bus.busy_o), 32'd0);
        check_ch0("single", 224, 192, 0);
        check("single_bitslip", 32'(bus.bitslip_o[1:0]), 32'd2);
        check("single_aligned", 32'(bus.aligned_data_o[3:0]), 32'b1000);
        check("single_loads", 32'(ld0_tot - ld0_base), 32'd17);
        check("single_no_ld1", 32'(ld1_tot - ld1_base), 32'd0);
        check("single_sel", 32'(bus.delay_sel_o), 32'd0);

        // Two runs: wider second run wins
        set_eye(32, 96, 256, 448, -1);
        start_scan(2'b01);
        wait_done("two");
        check_ch0("two", 352, 192, 0);
        check("two_tap", 32'(bus.delay_cntvaluein_o), 32'd352);

        // Tie: earlier run kept
        set_eye(0, 64, 192, 256, -1);
        start_scan(2'b01);
        wait_done("tie");
        check_ch0("tie", 32, 64, 0);

        // No eye
        set_eye(1000, -1, 1000, -1, -1);
        start_scan(2'b01);
        wait_done("noeye");
        check_ch0("noeye", 0, 0, 1);
        check("noeye_tap", 32'(bus.delay_cntvaluein_o), 32'd0);
        check("noeye_model_tap", 32'(tap_m), 32'd0);

        // Narrow eye below MIN_EYE
        set_eye(96, 128, 1000, -1, -1);
        start_scan(2'b01);
        wait_done("narrow");
        check_ch0("narrow", 0, 32, 1);
        check("narrow_tap", 32'(bus.delay_cntvaluein_o), 32'd0);

        // Glitch at 160 inside 128..320
        set_eye(128, 320, 1000, -1, 160);
        start_scan(2'b01);
        wait_done("glitch");
        check_ch0("glitch", 256, 128, 0);
        check("glitch_bitslip", 32'(bus.bitslip_o[1:0]), 32'd2);

        // Reset mid-SAMPLE
        set_eye(128, 320, 1000, -1, -1);
        start_scan(2'b01);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",    32'(bus.busy_o), 32'd0);
        check("midrst_center",  32'(bus.eye_center_o), 32'd0);
        check("midrst_width",   32'(bus.eye_width_o), 32'd0);
        check("midrst_bitslip", 32'(bus.bitslip_o), 32'd0);
        check("midrst_aligned", 32'(bus.aligned_data_o), 32'd0);
        check("midrst_load",    32'(bus.delay_load_o), 32'd0);
        check("midrst_tap",     32'(bus.delay_cntvaluein_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        ld0_base = ld0_tot;
        repeat (5) @(negedge clk);
        check("postrst_idle_busy", 32'(bus.busy_o), 32'd0);
        check("postrst_no_load", 32'(ld0_tot - ld0_base), 32'd0);

        // Fresh start with a stray start pulse mid-scan
        start_scan(2'b01);
        repeat (500) @(negedge clk);
        bus.chan_mask_i = 2'b11;
        bus.start_i     = 1'b1;
        @(negedge clk);
        bus.start_i     = 1'b0;
        wait_done("fresh");
        check_ch0("fresh", 224, 192, 0);
        check("fresh_loads", 32'(ld0_tot - ld0_base), 32'd17);
        check("fresh_no_ld1", 32'(ld1_tot - ld1_base), 32'd0);
        check("fresh_err1", 32'(bus.err_o[1]), 32'd0);
        @(negedge clk);
        check("fresh_done_pulse", 32'(bus.done_o), 32'd0);

        // Empty mask: done three cycles after start
        start_scan(2'b00);
        check("empty_busy", 32'(bus.busy_o), 32'd1);
        check("empty_done1", 32'(bus.done_o), 32'd0);
        @(negedge clk);
        check("empty_done2", 32'(bus.done_o), 32'd0);
        @(negedge clk);
        check("empty_done3", 32'(bus.done_o), 32'd1);
        check("empty_busy3", 32'(bus.busy_o), 32'd0);
        check("empty_keep_center", 32'(bus.eye_center_o[8:0]), 32'd224);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/turfio_eye_align.md
# turfio_eye_align

Parametrised multi-channel receive-alignment controller for TURFIO links. It drives the IDELAY load port of NBITS single-bit deserializer channels and sweeps each enabled channel's input delay across the tap range. At every delay point it checks the 4-bit ISERDES output against a rotation of a training nibble, then loads each channel's delay to the centre of its widest passing run. It also reports a per-channel bitslip, a rotated data output, and per-channel eye width and error flags, so software no longer has to run the delay scan itself.

## Interface
Parameters:
- NBITS, 4: number of channels.
- DWIDTH, 4: deserialized bits per channel per clock.
- PATTERN, 4'b1000: training nibble (DWIDTH bits). Must be aperiodic under rotation.
- DELAY_STEP, 32: tap increment per scan point.
- DELAY_MAX, 511: last tap allowed in the sweep (9-bit).
- SETTLE_CYCLES, 16: wait after each load before sampling.
- SAMPLE_LOG2, 8: sample window of 2^SAMPLE_LOG2 cycles.
- MIN_EYE, 64: minimum passing width in taps.

Ports:
- if_clk_i  in  1  interface clock; the only clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  single-cycle start pulse.
- chan_mask_i  in  NBITS  1 = scan this channel. Sampled at start.
- data_i  in  NBITS*DWIDTH  ISERDES outputs; channel c is at bits [c*DWIDTH +: DWIDTH].
- delay_load_o  out  NBITS  one-hot load strobe.
- delay_sel_o  out  2  delay select; always 2'b00 (IDELAY).
- delay_cntvaluein_o  out  9  tap value to load. Shared by all channels.
- busy_o  out  1  high from the cycle after start until done.
- done_o  out  1  single-cycle pulse when the scan completes.
- err_o  out  NBITS  channel failed to find a valid eye.
- eye_center_o  out  NBITS*9  tap loaded into each channel.
- eye_width_o  out  NBITS*9  best_end − best_start, in taps.
- bitslip_o  out  NBITS*log2(DWIDTH)  rotation applied to each channel.
- aligned_data_o  out  NBITS*DWIDTH  data_i rotated by bitslip, registered.

## Operation
FSM states: IDLE, SEL, LOAD, SETTLE, SAMPLE, EVAL, CENTER, CSETTLE, SLIP, DONE.

- **IDLE**
  - On start_i: latch chan_mask_i and set ch=0.
  - Clear err_o, eye_width_o and eye_center_o only for masked-in channels.
  - Go to SEL.
  - start_i is ignored in every non-IDLE state.
- **SEL**
  - Skip masked-out channels.
  - If ch reaches NBITS, go to DONE.
  - Otherwise set tap=0, clear run and best trackers, go to LOAD.
- **LOAD**
  - Pulse delay_load_o[ch] for one cycle with delay_cntvaluein_o=tap.
  - Go to SETTLE.
- **SETTLE**
  - Count SETTLE_CYCLES, then go to SAMPLE.
- **SAMPLE**
  - First cycle: capture ref = data_i[ch].
  - The point passes only if ref equals rotl(PATTERN,r) for some r, and every one of the 2^SAMPLE_LOG2 samples equals ref.
  - A mismatch marks the point as a fail, but the full window still runs.
- **EVAL**, for a pass:
  - If no run is open, run_start=tap.
  - Then run_end=tap.
- **EVAL**, for a fail, or a pass at the final point:
  - Close the open run.
  - It replaces best only if (run_end−run_start) is strictly greater than (best_end−best_start), or no best exists yet.
  - Ties keep the earlier run.
- **EVAL**, next step:
  - If tap+DELAY_STEP ≤ DELAY_MAX, add DELAY_STEP to tap and go to LOAD. Use 10-bit compare; no wrap.
  - Otherwise go to CENTER.
- **CENTER**, with a valid best (a best exists and width ≥ MIN_EYE):
  - center = best_start + ((best_end−best_start)>>1), 9-bit, no overflow possible.
  - Pulse the load with center.
- **CENTER**, otherwise:
  - Set err_o[ch]=1 and load tap 0.
- **CENTER**, both cases:
  - Write eye_center_o and eye_width_o for the channel.
  - Width is 0 if no pass was seen.
- **CSETTLE**
  - SETTLE_CYCLES wait, then go to SLIP.
- **SLIP**
  - bitslip[ch] = the lowest r with data_i[ch]==rotl(PATTERN,r).
  - If no r matches: bitslip=0 and err_o[ch]=1.
  - ch++, go to SEL.
- **DONE**
  - Pulse done_o, go to IDLE.
- **aligned_data_o**
  - Channel c = rotr(data_i[c], bitslip[c]), registered every cycle in every state.

Reset, asserted at any time, including mid-scan:
- All outputs go to 0, FSM to IDLE, and no load strobe is emitted.
- Previously loaded IDELAY taps are not restored.

## Timing
- delay_load_o is high exactly one cycle per LOAD or CENTER.
- delay_cntvaluein_o is valid in the same cycle and holds until the next load.
- Cycles per scan point: 1 (LOAD) + SETTLE_CYCLES + 2^SAMPLE_LOG2 + 1 (EVAL).
- Number of points: floor(DELAY_MAX/DELAY_STEP)+1.
- Per-channel finish: 1 (CENTER) + SETTLE_CYCLES + 1 (SLIP) + 1 (SEL).
- Per-channel result outputs update on the cycle after CENTER or SLIP.
- aligned_data_o latency is 1 cycle.
- busy_o falls in the same cycle done_o pulses.
- Empty mask: SEL goes straight to DONE, and done_o pulses 3 cycles after start_i.

## Test plan
- **Single eye.** NBITS=2, mask=01. The channel-0 model passes only for taps 128..320, returning rotl(PATTERN,2).
  - Required: 16 points scanned.
  - Required: center=224, width=192, bitslip=2, err=0, aligned_data_o[3:0]=PATTERN.
  - Required: delay_load_o[1] never asserts.
- **Two runs.** Passes at 32..96 and 256..448.
  - Required: best 256..448, center=352, width=192.
  - Tie case, passes 0..64 and 192..256: the first run is kept, center=32.
- **No eye.** All points fail.
  - Required: err_o[0]=1, width=0, center=0, the final load value is 0, done_o still pulses.
- **Narrow eye.** Passes only at 96..128 (width 32 < MIN_EYE).
  - Required: err=1, tap 0 loaded, width=32.
- **Glitch window.** One sample mismatch at tap 160 inside a 128..320 eye.
  - Required: 160 fails, best becomes 192..320, center=256.
- **Reset and start.** Assert rst_n_i mid-SAMPLE.
  - Required: outputs immediately 0 and FSM in IDLE.
  - Required: a start_i pulse while busy has no effect.
  - Required: a fresh start completes normally.
